key_event_encoder: RTL and testbench



---
 rtl/key_event_pkg.sv | 24 ++
 rtl/key_event_encoder_if.sv | 30 +++
 rtl/event_fifo.sv | 67 ++++++
 rtl/key_event_encoder.sv | 175 +++++++++++++++++
 tb/tb_key_event_encoder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/key_event_pkg.sv
// Shared types and sizing helpers for the keypad event encoder.
package key_event_pkg;

    localparam int KEYS_DEFAULT = 16;

    // Key code width for a given key count (never below one bit).
    function automatic int key_cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int KEY_CW = key_cw(KEYS_DEFAULT);

    typedef struct packed {
        logic              repeat_flag;
        logic [KEY_CW-1:0] code;
    } key_event_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

endpackage

// File: rtl/key_event_encoder_if.sv
// Event handshake between the keypad encoder and the calculator control FSM.
interface key_event_encoder_if
    import key_event_pkg::*;
#(
    parameter int CW = KEY_CW
) ();

    logic          ev_valid;
    logic [CW-1:0] ev_code;
    logic          ev_repeat;
    logic          ev_ready;
    logic          overflow;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_repeat,
        output overflow,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_repeat,
        input  overflow,
        output ev_ready
    );

endinterface

// File: rtl/event_fifo.sv
// First-word fall-through FIFO; when empty the output holds the last popped word.
module event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CNTW-1:0]  count;
    logic [WIDTH-1:0] last_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNTW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? last_q : mem[rd_ptr];

    // Storage write; cleared on reset so the output is never unknown.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and last-popped word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// Keypad event encoder: rising-edge press events, auto-repeat while held,
// buffered in a small FIFO behind a valid/ready handshake.
module key_event_encoder
    import key_event_pkg::*;
#(
    parameter int NUM_KEYS     = KEYS_DEFAULT,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] keys,
    key_event_encoder_if.master ev
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EVW     = $bits(key_event_t);

    logic                first_q;
    logic [NUM_KEYS-1:0] prev_keys;
    logic [NUM_KEYS-1:0] pending_q;
    logic [NUM_KEYS-1:0] rise;
    logic [NUM_KEYS-1:0] grant_mask;
    logic [KEY_CW-1:0]   grant_idx;
    logic                pending_any;
    logic                grant_valid;
    logic                pop;
    logic                can_accept;
    logic                fifo_full;
    logic                fifo_empty;

    rpt_state_t          state_q;
    rpt_state_t          state_d;
    logic [KEY_CW-1:0]   held_q;
    logic [KEY_CW-1:0]   held_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic                rpt_fire;
    logic                rpt_push;
    logic                push;
    logic                overflow_q;
    key_event_t          push_ev;
    key_event_t          head_ev;

    assign pop         = !fifo_empty && ev.ev_ready;
    assign can_accept  = !fifo_full || pop;
    assign grant_valid = pending_any && can_accept;
    assign grant_mask  = grant_valid ? (NUM_KEYS'(1) << grant_idx) : '0;
    // The first edge after reset only seeds prev_keys, so keys held through reset stay silent.
    assign rise        = first_q ? '0 : (keys & ~prev_keys);

    // Lowest-index pending press wins the grant.
    always_comb begin
        grant_idx   = '0;
        pending_any = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pending_q[i] && !pending_any) begin
                grant_idx   = KEY_CW'(i);
                pending_any = 1'b1;
            end
        end
    end

    // Edge detection and pending-press bookkeeping.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            first_q   <= 1'b1;
            prev_keys <= '0;
            pending_q <= '0;
        end else begin
            first_q   <= 1'b0;
            prev_keys <= keys;
            pending_q <= (pending_q | rise) & ~grant_mask;
        end
    end

    // Repeat FSM state, held key and cadence counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RPT_IDLE;
            held_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            cnt_q   <= cnt_d;
        end
    end

    // Repeat FSM next state; a fresh-press grant overrides everything and retargets.
    always_comb begin
        state_d  = state_q;
        held_d   = held_q;
        cnt_d    = cnt_q;
        rpt_fire = 1'b0;
        case (state_q)
            RPT_IDLE: begin
                cnt_d = cnt_q;
            end
            RPT_DELAY: begin
                if (!keys[held_q]) begin
                    state_d = RPT_IDLE;
                end else if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
                    rpt_fire = 1'b1;
                    cnt_d    = '0;
                    state_d  = RPT_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RPT_REPEAT: begin
                if (!keys[held_q]) begin
                    state_d = RPT_IDLE;
                end else if (cnt_q == CNT_W'(REPEAT_RATE - 1)) begin
                    rpt_fire = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RPT_IDLE;
            end
        endcase
        if (grant_valid) begin
            held_d  = grant_idx;
            cnt_d   = '0;
            state_d = RPT_DELAY;
        end
    end

    assign rpt_push = rpt_fire && !grant_valid && can_accept;
    assign push     = grant_valid || rpt_push;

    // Fresh presses take the single FIFO slot per cycle ahead of repeats.
    always_comb begin
        push_ev.repeat_flag = 1'b0;
        push_ev.code        = grant_idx;
        if (!grant_valid) begin
            push_ev.repeat_flag = 1'b1;
            push_ev.code        = held_q;
        end
    end

    // Sticky flag for repeats lost to a full FIFO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (rpt_fire && !can_accept) begin
            overflow_q <= 1'b1;
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVW)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_ev),
        .pop     (pop),
        .dout    (head_ev),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ev.ev_valid  = !fifo_empty;
    assign ev.ev_code   = head_ev.code;
    assign ev.ev_repeat = head_ev.repeat_flag;
    assign ev.overflow  = overflow_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed bench for key_event_encoder with a timed event scoreboard.
module tb_key_event_encoder;
    import key_event_pkg::*;

    typedef struct {
        int code;
        bit rpt;
        int cyc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic [15:0] keys;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    int          c0;

    key_event_encoder_if #(.CW(4)) bus ();

    key_event_encoder #(
        .NUM_KEYS     (16),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .keys    (keys),
        .ev      (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_ev(input int code, input bit rpt, input int at);
        exp_t e;
        e.code = code;
        e.rpt  = rpt;
        e.cyc  = at;
        sb.push_back(e);
    endtask

    // Monitor: compare every accepted event against the scoreboard head.
    always @(negedge clock) begin
        exp_t e;
        #1;
        if (reset_n && bus.ev_valid && bus.ev_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_event observed=code%0d/rpt%0d@%0d expected=none",
                       bus.ev_code, bus.ev_repeat, cyc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ev_code", bus.ev_code, e.code);
                chk("ev_repeat", bus.ev_repeat, e.rpt);
                if (e.cyc >= 0) chk("ev_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        keys         = '0;
        bus.ev_ready = 1'b1;
        reset_n      = 1'b0;
        step(3);
        chk("rst_valid", bus.ev_valid, 0);
        chk("rst_code", bus.ev_code, 0);
        chk("rst_repeat", bus.ev_repeat, 0);
        chk("rst_overflow", bus.overflow, 0);
        reset_n = 1'b1;
        step(3);

        // Single tap of key 5 for three cycles.
        c0 = cyc;
        keys[5] = 1'b1;
        expect_ev(5, 0, c0 + 2);
        step(3);
        keys[5] = 1'b0;
        #1 chk("tap_valid_one_cycle", bus.ev_valid, 0);
        step(12);
        chk("tap_sb_empty", sb.size(), 0);

        // Hold key 3 for twenty cycles: press then three repeats.
        c0 = cyc;
        keys[3] = 1'b1;
        expect_ev(3, 0, c0 + 2);
        expect_ev(3, 1, c0 + 10);
        expect_ev(3, 1, c0 + 14);
        expect_ev(3, 1, c0 + 18);
        step(20);
        keys[3] = 1'b0;
        step(12);
        chk("hold_sb_empty", sb.size(), 0);

        // Keys 9 and 2 together: priority order, repeat follows key 9.
        c0 = cyc;
        keys[9] = 1'b1;
        keys[2] = 1'b1;
        expect_ev(2, 0, c0 + 2);
        expect_ev(9, 0, c0 + 3);
        expect_ev(9, 1, c0 + 11);
        step(13);
        keys[9] = 1'b0;
        keys[2] = 1'b0;
        step(10);
        chk("simul_sb_empty", sb.size(), 0);

        // Backpressure: five taps into a four-entry FIFO.
        bus.ev_ready = 1'b0;
        c0 = cyc;
        for (int i = 0; i < 5; i++) expect_ev(i, 0, c0 + 12 + i);
        for (int i = 0; i < 5; i++) begin
            keys[i] = 1'b1;
            step(1);
            keys[i] = 1'b0;
            step(1);
        end
        step(2);
        chk("bp_head_valid", bus.ev_valid, 1);
        chk("bp_head_code", bus.ev_code, 0);
        chk("bp_overflow", bus.overflow, 0);
        bus.ev_ready = 1'b1;
        step(10);
        chk("bp_overflow_after", bus.overflow, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // Repeat drop while the FIFO is full, then cadence after draining.
        chk("drop_pre_overflow", bus.overflow, 0);
        bus.ev_ready = 1'b0;
        c0 = cyc;
        expect_ev(0, 0, c0 + 21);
        expect_ev(1, 0, c0 + 22);
        expect_ev(2, 0, c0 + 23);
        expect_ev(7, 0, c0 + 24);
        expect_ev(7, 1, c0 + 25);
        expect_ev(7, 1, c0 + 28);
        expect_ev(7, 1, c0 + 32);
        for (int i = 0; i < 3; i++) begin
            keys[i] = 1'b1;
            step(1);
            keys[i] = 1'b0;
            step(1);
        end
        keys[7] = 1'b1;
        step(12);
        chk("drop_overflow_set", bus.overflow, 1);
        step(3);
        bus.ev_ready = 1'b1;
        step(12);
        keys[7] = 1'b0;
        step(10);
        chk("drop_overflow_sticky", bus.overflow, 1);
        chk("drop_sb_empty", sb.size(), 0);

        // Reset with events queued and key 6 held.
        bus.ev_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            keys[i] = 1'b1;
            step(1);
            keys[i] = 1'b0;
            step(1);
        end
        keys[6] = 1'b1;
        step(4);
        chk("mid_valid_before", bus.ev_valid, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.ev_valid, 0);
        chk("mid_rst_overflow", bus.overflow, 0);
        step(2);
        reset_n = 1'b1;
        bus.ev_ready = 1'b1;
        step(15);
        chk("mid_no_event_valid", bus.ev_valid, 0);
        chk("mid_sb_empty", sb.size(), 0);
        keys[6] = 1'b0;
        step(3);
        c0 = cyc;
        keys[6] = 1'b1;
        expect_ev(6, 0, c0 + 2);
        step(4);
        keys[6] = 1'b0;
        step(10);
        chk("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
